// File: rtl/pipe_trace_mon.sv
// Execution-trace monitor: packs fetch / store / register-writeback events
// into typed records, buffers them in a multi-write FIFO and streams them out.
module pipe_trace_mon #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_INSTR = 17,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] fetch_pc,
  input  logic              st_en,
  input  logic [DATA_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              reg_wr_en,
  input  logic [REG_W-1:0]  reg_wr_num,
  input  logic [DATA_W-1:0] reg_wr_data,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [1:0]        rec_kind,
  output logic [DATA_W-1:0] rec_a,
  output logic [DATA_W-1:0] rec_b,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       instr_count,
  output logic [15:0]       drop_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned DCW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_ST  = 2'd1;
  localparam logic [1:0] KIND_REG = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DCW-1:0]    drain_cnt_q;
  logic [1:0]        kind_mem [DEPTH];
  logic [DATA_W-1:0] a_mem    [DEPTH];
  logic [DATA_W-1:0] b_mem    [DEPTH];

  logic [PW-1:0] occ_c;
  logic [PW:0]   free_c;
  logic          wb_c, st_c, pc_c;
  logic [1:0]    n_c, off_st_c, off_pc_c;
  logic          drop_c, pop_c, start_ok_c, fetch_last_c;
  logic [AW-1:0] idx_wb_c, idx_st_c, idx_pc_c, head_c;

  // Occupancy, capture qualification and per-cycle write slot allocation (WB, ST, PC)
  always_comb begin
    occ_c        = wr_ptr_q - rd_ptr_q;
    free_c       = (PW+1)'(DEPTH) - {1'b0, occ_c};
    wb_c         = ((state_q == S_RUN) || (state_q == S_DRAIN)) && reg_wr_en;
    st_c         = ((state_q == S_RUN) || (state_q == S_DRAIN)) && st_en;
    pc_c         = (state_q == S_RUN) && fetch_en;
    n_c          = 2'(wb_c) + 2'(st_c) + 2'(pc_c);
    drop_c       = (PW+1)'(n_c) > free_c;
    off_st_c     = 2'(wb_c);
    off_pc_c     = 2'(wb_c) + 2'(st_c);
    idx_wb_c     = wr_ptr_q[AW-1:0];
    idx_st_c     = wr_ptr_q[AW-1:0] + AW'(off_st_c);
    idx_pc_c     = wr_ptr_q[AW-1:0] + AW'(off_pc_c);
    head_c       = rd_ptr_q[AW-1:0];
    rec_valid    = (occ_c != '0);
    pop_c        = rec_valid && rec_ready;
    start_ok_c   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    fetch_last_c = pc_c && (MAX_INSTR != 0) &&
                   ((instr_count + 16'd1) == 16'(MAX_INSTR));
  end

  // Show-ahead head of the FIFO; zero when empty
  always_comb begin
    rec_kind = 2'd0;
    rec_a    = '0;
    rec_b    = '0;
    if (rec_valid) begin
      rec_kind = kind_mem[head_c];
      rec_a    = a_mem[head_c];
      rec_b    = b_mem[head_c];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok_c) state_d = S_RUN;
      S_RUN:   if (fetch_last_c) state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt_q <= DCW'(1)) state_d = S_FLUSH;
      S_FLUSH: if (occ_c == '0) state_d = S_DONE;
      S_DONE:  if (start_ok_c) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Status flags follow the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_FLUSH);
      done <= (state_d == S_DONE);
    end
  end

  // Drain countdown: loaded on the final fetch, decremented while draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt_q <= '0;
    end else if (fetch_last_c) begin
      drain_cnt_q <= DCW'(DRAIN_CYC);
    end else if ((state_q == S_DRAIN) && (drain_cnt_q != '0)) begin
      drain_cnt_q <= drain_cnt_q - DCW'(1);
    end
  end

  // FIFO pointers, run counters and overflow bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      instr_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (start_ok_c) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      instr_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else begin
        wr_ptr_q <= wr_ptr_q + PW'(n_c);
      end
      // A dropped fetch still counts so run length tracks the program
      if (pc_c) instr_count <= instr_count + 16'd1;
    end
  end

  // Record storage: up to three writes per cycle into consecutive slots
  always_ff @(posedge clk) begin
    if (!drop_c) begin
      if (wb_c) begin
        kind_mem[idx_wb_c] <= KIND_REG;
        a_mem[idx_wb_c]    <= DATA_W'(reg_wr_num);
        b_mem[idx_wb_c]    <= reg_wr_data;
      end
      if (st_c) begin
        kind_mem[idx_st_c] <= KIND_ST;
        a_mem[idx_st_c]    <= st_addr;
        b_mem[idx_st_c]    <= st_data;
      end
      if (pc_c) begin
        kind_mem[idx_pc_c] <= KIND_PC;
        a_mem[idx_pc_c]    <= fetch_pc;
        b_mem[idx_pc_c]    <= '0;
      end
    end
  end

endmodule
